// File: rtl/dot_seq_pkg.sv
// Shared definitions for the packed int16 dot-product sequencer and its
// combinational pair-reduction datapath.
package dot_seq_pkg;

  typedef enum logic [2:0] {
    IDLE,
    FETCH_A,
    FETCH_B,
    ACC,
    DONE
  } state_e;

  // Element positions inside one packed 32-bit word.
  localparam int LO_LSB = 0;
  localparam int LO_MSB = 15;
  localparam int HI_LSB = 16;
  localparam int HI_MSB = 31;

  localparam longint INT32_MAX = 64'sd2147483647;
  localparam longint INT32_MIN = -64'sd2147483648;

endpackage

// File: rtl/dot_seq_if.sv
// Launch, memory read and result handshake signals of the dot sequencer.
// The slave view belongs to dot_seq, the master view to its surroundings.
interface dot_seq_if #(
  parameter int ADDR_W = 32,
  parameter int LEN_W  = 16
);
  logic              start;
  logic [ADDR_W-1:0] a_base;
  logic [ADDR_W-1:0] b_base;
  logic [LEN_W-1:0]  len;
  logic              busy;
  logic              mem_re;
  logic [ADDR_W-1:0] mem_addr;
  logic [31:0]       mem_rdata;
  logic              res_valid;
  logic              res_ready;
  logic [31:0]       result;
  logic              overflow;

  modport slave (
    input  start, a_base, b_base, len, mem_rdata, res_ready,
    output busy, mem_re, mem_addr, res_valid, result, overflow
  );

  modport master (
    output start, a_base, b_base, len, mem_rdata, res_ready,
    input  busy, mem_re, mem_addr, res_valid, result, overflow
  );
endinterface

// File: rtl/dot_seq_packed_dot2.sv
// Exact signed reduction of one packed word pair: a.lo*b.lo + a.hi*b.hi.
// Also used by the ALU packed-dot path, so both produce identical results.
module packed_dot2
  import dot_seq_pkg::*;
(
  input  logic [31:0]        a,
  input  logic [31:0]        b,
  output logic signed [32:0] dot
);
  logic signed [15:0] a_lo, a_hi, b_lo, b_hi;
  logic signed [31:0] p_lo, p_hi;

  // NOTE: every signal written here gets a value on every path, so no latch is inferred.
  always_comb begin
    a_lo = a[LO_MSB:LO_LSB];
    a_hi = a[HI_MSB:HI_LSB];
    b_lo = b[LO_MSB:LO_LSB];
    b_hi = b[HI_MSB:HI_LSB];
    p_lo = a_lo * b_lo;
    p_hi = a_hi * b_hi;
    // Two maximal products sum to 2^31, hence the extra 33rd bit.
    dot  = $signed({p_lo[31], p_lo}) + $signed({p_hi[31], p_hi});
  end
endmodule

// File: rtl/dot_seq.sv
// Sequencer fetching A/B word pairs, reducing each pair and accumulating the
// dot product; the result is offered on a valid/ready handshake.
module dot_seq
  import dot_seq_pkg::*;
#(
  parameter int ADDR_W      = 32,
  parameter int LEN_W       = 16,
  parameter int ADDR_STRIDE = 4,
  parameter int ACC_W       = 40
) (
  input  logic     clk,
  input  logic     rst_n,
  dot_seq_if.slave bus
);
  localparam logic signed [ACC_W-1:0] ACC_MAX = ACC_W'(INT32_MAX);
  localparam logic signed [ACC_W-1:0] ACC_MIN = ACC_W'(INT32_MIN);
  localparam logic [ADDR_W-1:0]       STRIDE  = ADDR_W'(ADDR_STRIDE);

  state_e                   state_q, state_d;
  logic [ADDR_W-1:0]        a_ptr_q, a_ptr_d;
  logic [ADDR_W-1:0]        b_ptr_q, b_ptr_d;
  logic [LEN_W-1:0]         cnt_q, cnt_d;
  logic [31:0]              a_reg_q, a_reg_d;
  logic signed [ACC_W-1:0]  acc_q, acc_d;
  logic signed [32:0]       dot2;

  // B word arrives on mem_rdata during ACC and is reduced combinationally.
  packed_dot2 u_dot2 (
    .a   (a_reg_q),
    .b   (bus.mem_rdata),
    .dot (dot2)
  );

  // NOTE: sequential state uses non-blocking assignments so all flops update together.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      a_ptr_q <= '0;
      b_ptr_q <= '0;
      cnt_q   <= '0;
      a_reg_q <= '0;
      acc_q   <= '0;
    end else begin
      state_q <= state_d;
      a_ptr_q <= a_ptr_d;
      b_ptr_q <= b_ptr_d;
      cnt_q   <= cnt_d;
      a_reg_q <= a_reg_d;
      acc_q   <= acc_d;
    end
  end

  always_comb begin
    state_d = state_q;
    a_ptr_d = a_ptr_q;
    b_ptr_d = b_ptr_q;
    cnt_d   = cnt_q;
    a_reg_d = a_reg_q;
    acc_d   = acc_q;
    unique case (state_q)
      IDLE: begin
        if (bus.start) begin
          a_ptr_d = bus.a_base;
          b_ptr_d = bus.b_base;
          cnt_d   = bus.len;
          acc_d   = '0;
          state_d = (bus.len == '0) ? DONE : FETCH_A;
        end
      end
      FETCH_A: state_d = FETCH_B;
      FETCH_B: begin
        a_reg_d = bus.mem_rdata;
        state_d = ACC;
      end
      ACC: begin
        acc_d   = acc_q + ACC_W'(dot2);
        a_ptr_d = a_ptr_q + STRIDE;
        b_ptr_d = b_ptr_q + STRIDE;
        cnt_d   = cnt_q - LEN_W'(1);
        state_d = (cnt_q == LEN_W'(1)) ? DONE : FETCH_A;
      end
      DONE: begin
        // Start is not looked at here; a launch needs a cycle spent in IDLE.
        if (bus.res_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    bus.busy      = (state_q != IDLE);
    bus.mem_re    = 1'b0;
    bus.mem_addr  = '0;
    if (state_q == FETCH_A) begin
      bus.mem_re   = 1'b1;
      bus.mem_addr = a_ptr_q;
    end else if (state_q == FETCH_B) begin
      bus.mem_re   = 1'b1;
      bus.mem_addr = b_ptr_q;
    end
    bus.res_valid = (state_q == DONE);
    bus.result    = acc_q[31:0];
    bus.overflow  = (acc_q > ACC_MAX) || (acc_q < ACC_MIN);
  end
endmodule

// File: tb/tb_dot_seq.sv
// Randomized and directed bench for dot_seq with a cycle-level reference
// model derived from the launch timing and plain integer arithmetic.
module tb_dot_seq;
  logic clk;
  logic rst_n;
  int   tests_run = 0;
  int   tests_failed = 0;

  dot_seq_if #(.ADDR_W(32), .LEN_W(16)) bus ();

  dot_seq #(.ADDR_W(32), .LEN_W(16), .ADDR_STRIDE(4), .ACC_W(40)) u_dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic [31:0] mem [logic [31:0]];

  function automatic logic [31:0] mem_rd(input logic [31:0] addr);
    if (mem.exists(addr)) return mem[addr];
    return 32'h0BAD_F00D;
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests_run++;
    if (act !== exp) begin
      tests_failed++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Memory responder: data for a read seen in cycle k is presented in cycle k+1.
  logic        nxt_re = 1'b0;
  logic [31:0] nxt_addr = '0;
  always @(negedge clk) begin
    nxt_re   = bus.mem_re;
    nxt_addr = bus.mem_addr;
  end
  always @(posedge clk) begin
    #1;
    bus.mem_rdata = nxt_re ? mem_rd(nxt_addr) : $urandom;
  end

  function automatic longint model_dot(input logic [31:0] a, input logic [31:0] b, input int n);
    longint s = 0;
    for (int i = 0; i < n; i++) begin
      logic [31:0] wa, wb;
      shortint al, ah, bl, bh;
      wa = mem_rd(a + 32'(4 * i));
      wb = mem_rd(b + 32'(4 * i));
      al = wa[15:0]; ah = wa[31:16];
      bl = wb[15:0]; bh = wb[31:16];
      s += longint'(al) * longint'(bl) + longint'(ah) * longint'(bh);
    end
    return s;
  endfunction

  // Reference model: job timeline counted in cycles since the launch edge.
  logic        m_busy = 1'b0;
  int          m_cyc = 0;
  int          m_len = 0;
  logic [31:0] m_a = '0, m_b = '0;
  longint      m_acc = 0;

  always @(negedge clk) begin
    if (!rst_n) begin
      m_busy = 1'b0;
      check("rst_busy", bus.busy, 0);
      check("rst_mem_re", bus.mem_re, 0);
      check("rst_mem_addr", bus.mem_addr, 0);
      check("rst_res_valid", bus.res_valid, 0);
      check("rst_result", bus.result, 0);
      check("rst_overflow", bus.overflow, 0);
    end else begin
      if (!m_busy) begin
        check("idle_busy", bus.busy, 0);
        check("idle_mem_re", bus.mem_re, 0);
        check("idle_res_valid", bus.res_valid, 0);
      end else if (m_cyc <= 3 * m_len) begin
        int i, r;
        logic [31:0] exp_addr;
        i = (m_cyc - 1) / 3;
        r = (m_cyc - 1) % 3;
        exp_addr = (r == 0) ? m_a + 32'(4 * i) : m_b + 32'(4 * i);
        check("run_busy", bus.busy, 1);
        check("run_res_valid", bus.res_valid, 0);
        check("run_mem_re", bus.mem_re, (r != 2));
        if (r != 2) check("run_mem_addr", bus.mem_addr, exp_addr);
      end else begin
        check("done_busy", bus.busy, 1);
        check("done_res_valid", bus.res_valid, 1);
        check("done_mem_re", bus.mem_re, 0);
        check("done_result", bus.result, m_acc[31:0]);
        check("done_overflow", bus.overflow,
              (m_acc > 64'sd2147483647) || (m_acc < -64'sd2147483648));
      end
      // Decide what the upcoming edge does.
      if (!m_busy) begin
        if (bus.start) begin
          m_busy = 1'b1;
          m_cyc  = 1;
          m_a    = bus.a_base;
          m_b    = bus.b_base;
          m_len  = int'(bus.len);
          m_acc  = model_dot(m_a, m_b, m_len);
        end
      end else if (m_cyc > 3 * m_len) begin
        if (bus.res_ready) m_busy = 1'b0;
      end else begin
        m_cyc++;
      end
    end
  end

  task automatic launch(input logic [31:0] a, input logic [31:0] b, input logic [15:0] l);
    @(posedge clk); #2;
    bus.start = 1'b1; bus.a_base = a; bus.b_base = b; bus.len = l;
    @(posedge clk); #2;
    bus.start = 1'b0; bus.a_base = $urandom; bus.b_base = $urandom; bus.len = 16'($urandom);
  endtask

  // Entered at +2 into cycle 'first'; returns at the negedge of the first valid cycle.
  task automatic wait_valid(input string tag, input int first, output int cyc);
    cyc = first;
    @(negedge clk);
    while (!bus.res_valid && cyc < first + 300) begin
      @(negedge clk);
      cyc++;
    end
    check({tag, "_valid_seen"}, bus.res_valid, 1);
  endtask

  task automatic accept(input int delay);
    repeat (delay) @(posedge clk);
    @(posedge clk); #2;
    bus.res_ready = 1'b1;
    @(posedge clk); #2;
    bus.res_ready = 1'b0;
    @(negedge clk);
    check("accept_idle_busy", bus.busy, 0);
  endtask

  task automatic directed(input string tag, input logic [31:0] a, input logic [31:0] b,
                          input logic [15:0] l, input int exp_cyc,
                          input logic [31:0] exp_res, input logic exp_ovf);
    int cyc;
    launch(a, b, l);
    wait_valid(tag, 1, cyc);
    check({tag, "_cycle"}, cyc, exp_cyc);
    check({tag, "_result"}, bus.result, exp_res);
    check({tag, "_overflow"}, bus.overflow, exp_ovf);
    accept(0);
  endtask

  initial begin
    int cyc;
    bus.start = 1'b0; bus.a_base = '0; bus.b_base = '0; bus.len = '0;
    bus.res_ready = 1'b0; bus.mem_rdata = '0;
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    @(posedge clk); #3;
    rst_n = 1'b1;

    mem[32'h100] = 32'h0002_0003; mem[32'h104] = 32'hFFFF_0001; mem[32'h108] = 32'h0000_0000;
    mem[32'h200] = 32'h0005_0004; mem[32'h204] = 32'h0003_0002; mem[32'h208] = 32'h1234_5678;
    mem[32'h300] = 32'h8000_8000; mem[32'h304] = 32'h0000_FFFF;
    mem[32'h400] = 32'h8000_8000; mem[32'h404] = 32'h0000_0001;

    directed("len1", 32'h100, 32'h200, 16'd1, 4, 32'h0000_0016, 1'b0);
    directed("len3", 32'h100, 32'h200, 16'd3, 10, 32'h0000_0015, 1'b0);
    directed("ovf_hi", 32'h300, 32'h400, 16'd1, 4, 32'h8000_0000, 1'b1);
    directed("ovf_back", 32'h300, 32'h400, 16'd2, 7, 32'h7FFF_FFFF, 1'b0);

    // Zero length: immediate result, held while the consumer stalls.
    launch(32'h100, 32'h200, 16'd0);
    wait_valid("len0", 1, cyc);
    check("len0_cycle", cyc, 1);
    for (int k = 0; k < 5; k++) begin
      check("len0_hold_result", bus.result, 0);
      check("len0_hold_busy", bus.busy, 1);
      check("len0_hold_overflow", bus.overflow, 0);
      @(posedge clk); #2;
      bus.start = (k == 2); bus.len = 16'd3;
      @(negedge clk);
    end
    bus.start = 1'b0;
    accept(0);

    // Start pulse during FETCH_B is ignored.
    launch(32'h100, 32'h200, 16'd3);
    @(posedge clk); #2;
    bus.start = 1'b1; bus.a_base = 32'h300; bus.b_base = 32'h400; bus.len = 16'd1;
    @(posedge clk); #2;
    bus.start = 1'b0;
    wait_valid("busy_start", 3, cyc);
    check("busy_start_cycle", cyc, 10);
    check("busy_start_result", bus.result, 32'h0000_0015);
    accept(1);

    // Reset during ACC of word 2 of 4, then a clean job.
    for (int i = 0; i < 4; i++) begin
      mem[32'h500 + 32'(4 * i)] = $urandom;
      mem[32'h600 + 32'(4 * i)] = $urandom;
    end
    launch(32'h500, 32'h600, 16'd4);
    repeat (5) @(posedge clk);
    #1 rst_n = 1'b0;
    #1;
    check("async_rst_busy", bus.busy, 0);
    check("async_rst_mem_re", bus.mem_re, 0);
    check("async_rst_mem_addr", bus.mem_addr, 0);
    check("async_rst_res_valid", bus.res_valid, 0);
    check("async_rst_result", bus.result, 0);
    check("async_rst_overflow", bus.overflow, 0);
    @(negedge clk); #2;
    rst_n = 1'b1;
    directed("after_rst", 32'h100, 32'h200, 16'd1, 4, 32'h0000_0016, 1'b0);

    // Randomized jobs: wrapping bases, stray start/ready, variable consumer delay.
    for (int j = 0; j < 40; j++) begin
      logic [31:0] a, b;
      int l, n;
      l = $urandom_range(0, 6);
      a = ($urandom_range(0, 3) == 0) ? 32'hFFFF_FFF0 : ($urandom & 32'hFFFF_FFFC);
      b = ($urandom_range(0, 3) == 0) ? 32'hFFFF_FFF4 : ($urandom & 32'hFFFF_FFFC);
      for (int i = 0; i < l; i++) begin
        mem[a + 32'(4 * i)] = ($urandom_range(0, 4) == 0) ? 32'h8000_8000 : $urandom;
        mem[b + 32'(4 * i)] = ($urandom_range(0, 4) == 0) ? 32'h8000_8000 : $urandom;
      end
      launch(a, b, 16'(l));
      n = 0;
      while (!bus.res_valid && n < 100) begin
        bus.start     = ($urandom_range(0, 3) == 0);
        bus.res_ready = ($urandom_range(0, 3) == 0);
        bus.a_base    = $urandom;
        bus.len       = 16'($urandom_range(0, 6));
        @(posedge clk); #2;
        n++;
      end
      bus.start = 1'b0; bus.res_ready = 1'b0;
      check("rand_valid_seen", bus.res_valid, 1);
      repeat ($urandom_range(0, 3)) @(posedge clk);
      @(posedge clk); #2;
      bus.res_ready = 1'b1;
      bus.start     = ($urandom_range(0, 1) == 1);
      @(posedge clk); #2;
      bus.res_ready = 1'b0;
      bus.start     = 1'b0;
      @(negedge clk);
    end

    repeat (3) @(posedge clk);
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end
endmodule
